// File: rtl/cla_multicycle_add_ctrl.sv
// Wide add/subtract built from one 4-bit carry-lookahead slice, stepped LSB nibble
// first over WIDTH/4 cycles, with valid/ready handshakes on both sides.
module cla_multicycle_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDX_W  = $clog2(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Operands shift right one nibble per RUN cycle, so the slice always reads bits [3:0].
  logic [3:0] sl_a, sl_b, sl_g, sl_p, sl_sum;
  logic [4:0] sl_c;

  assign sl_a = a_q[3:0];
  assign sl_b = b_q[3:0];
  assign sl_g = sl_a & sl_b;
  assign sl_p = sl_a ^ sl_b;

  assign sl_c[0] = carry_q;
  assign sl_c[1] = sl_g[0] | (sl_p[0] & sl_c[0]);
  assign sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_c[0]);
  assign sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
                 | (sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
  assign sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
                 | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
                 | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
  assign sl_sum  = sl_p ^ sl_c[3:0];

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub | in_cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = sl_c[4];
        for (int i = 0; i < NSLICE; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[4*i +: 4] = sl_sum;
        end
        if (idx_q == LAST_IDX) begin
          // On the last slice sl_a[3]/sl_b[3] are the operand MSBs.
          state_d = S_DONE;
          idx_d   = '0;
          cout_d  = sl_c[4];
          ovf_d   = (sl_a[3] == sl_b[3]) && (sl_sum[3] != sl_a[3]);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: operand and result registers are reset too, so outputs are defined and no
  // stale carry or partial sum survives an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_multicycle_add_ctrl.sv
// Bench for cla_multicycle_add_ctrl at WIDTH 8/16/32: directed corner cases on the
// 16-bit instance, then randomized operations with stalls against an arithmetic model.
module tb_cla_multicycle_add_ctrl;

  localparam int NINST = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [NINST];
  logic        in_ready  [NINST];
  logic        in_sub    [NINST];
  logic        in_cin    [NINST];
  logic        out_valid [NINST];
  logic        out_ready [NINST];
  logic        out_cout  [NINST];
  logic        out_ovf   [NINST];
  logic        busy      [NINST];
  logic [31:0] in_a      [NINST];
  logic [31:0] in_b      [NINST];
  logic [31:0] out_sum   [NINST];

  int n_checks = 0;
  int n_errors = 0;
  int acc_wait = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NINST; k++) begin : g_dut
    localparam int W = (k == 0) ? 8 : (k == 1) ? 16 : 32;
    logic [W-1:0] sum_w;

    cla_multicycle_add_ctrl #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_a      (in_a[k][W-1:0]),
      .in_b      (in_b[k][W-1:0]),
      .in_sub    (in_sub[k]),
      .in_cin    (in_cin[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_sum   (sum_w),
      .out_cout  (out_cout[k]),
      .out_ovf   (out_ovf[k]),
      .busy      (busy[k])
    );

    assign out_sum[k] = 32'(sum_w);
  end

  function automatic int width_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 16 : 32;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned result from plain integer add/subtract, overflow from the
  // exact signed result falling outside the WIDTH-bit two's-complement range.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic sub, input logic cin,
                                output logic [31:0] s, output logic co, output logic ov);
    longint m, half, ua, ub, full, sa, sb, ex;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    full = sub ? (ua + (m + 1) - ub) : (ua + ub + longint'(cin));
    s    = 32'(full & m);
    co   = ((full >> w) & 1) != 0;
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sb   = (ub >= half) ? ub - (m + 1) : ub;
    ex   = sub ? (sa - sb) : (sa + sb + longint'(cin));
    ov   = (ex >= half) || (ex < -half);
  endfunction

  function automatic logic [31:0] rand_operand(input int w);
    longint m, half;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    case ($urandom_range(0, 5))
      0:       return 32'(0);
      1:       return 32'(m);
      2:       return 32'(half);
      3:       return 32'(half - 1);
      default: return 32'(longint'($urandom()) & m);
    endcase
  endfunction

  // One full transaction: request, RUN with ignored noise on the inputs, DONE held
  // for 'stall' cycles with in_valid high, then the result handshake.
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic cin,
                        input int idle_cyc, input int stall, input string tag);
    int          w, n;
    logic [31:0] es;
    logic        ec, eo;
    w = width_of(k);
    model(w, a, b, sub, cin, es, ec, eo);
    repeat (idle_cyc) cyc();

    in_a[k] = a; in_b[k] = b; in_sub[k] = sub; in_cin[k] = cin; in_valid[k] = 1'b1;
    n = 0;
    while (!in_ready[k] && n < 50) begin
      cyc();
      n++;
    end
    acc_wait = n;
    check({tag, "_accept_timeout"}, 64'(n < 50), 64'd1);
    cyc();

    n = 0;
    while (!out_valid[k] && n < w) begin
      check({tag, "_run_busy"}, 64'({busy[k], in_ready[k]}), 64'b10);
      in_valid[k]  = 1'($urandom_range(0, 1));
      in_a[k]      = $urandom();
      in_b[k]      = $urandom();
      in_sub[k]    = 1'($urandom_range(0, 1));
      in_cin[k]    = 1'($urandom_range(0, 1));
      out_ready[k] = 1'($urandom_range(0, 1));
      cyc();
      n++;
    end
    out_ready[k] = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'(w / 4));
    check({tag, "_sum"}, 64'(out_sum[k]), 64'(es));
    check({tag, "_cout"}, 64'(out_cout[k]), 64'(ec));
    check({tag, "_ovf"}, 64'(out_ovf[k]), 64'(eo));

    repeat (stall) begin
      in_valid[k] = 1'b1;
      in_a[k]     = $urandom();
      cyc();
      check({tag, "_hold_flags"}, 64'({out_valid[k], in_ready[k], busy[k]}), 64'b101);
      check({tag, "_hold_result"}, 64'({out_sum[k], out_cout[k], out_ovf[k]}),
            64'({es, ec, eo}));
    end

    out_ready[k] = 1'b1;
    cyc();
    out_ready[k] = 1'b0;
    in_valid[k]  = 1'b0;
    check({tag, "_after_hs"}, 64'({out_valid[k], in_ready[k], busy[k]}), 64'b010);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NINST; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_sub[k] = 1'b0; in_cin[k] = 1'b0;
      in_a[k] = '0; in_b[k] = '0;
    end
    #12;
    for (int k = 0; k < NINST; k++) begin
      check("reset_flags", 64'({out_valid[k], in_ready[k], busy[k]}), 64'b010);
      check("reset_result", 64'({out_sum[k], out_cout[k], out_ovf[k]}), 64'd0);
    end
    rst_n = 1'b1;
    cyc();

    run_op(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 0, "add_wrap");
    run_op(1, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 0, 0, "add_ovf");
    run_op(1, 32'h0000_1234, 32'h0000_4321, 1'b0, 1'b1, 1, 0, "add_cin");
    run_op(1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 0, 2, "sub_neg");
    run_op(1, 32'h0000_8000, 32'h0000_0001, 1'b1, 1'b1, 0, 0, "sub_ovf");
    run_op(1, 32'h0000_0003, 32'h0000_0003, 1'b1, 1'b0, 0, 0, "sub_zero");

    run_op(1, 32'h0000_A5A5, 32'h0000_5A5A, 1'b0, 1'b0, 0, 10, "bp");
    run_op(1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 0, 0, "bp_next");
    check("bp_next_accept_wait", 64'(acc_wait), 64'd0);

    // Abort an operation whose first nibble left carry=1, then confirm a clean restart.
    in_a[1] = 32'h0000_FFFF; in_b[1] = 32'h0000_0001; in_sub[1] = 1'b0; in_cin[1] = 1'b0;
    in_valid[1] = 1'b1;
    cyc();
    in_valid[1] = 1'b0;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check("abort_flags", 64'({out_valid[1], in_ready[1], busy[1]}), 64'b010);
    check("abort_result", 64'({out_sum[1], out_cout[1], out_ovf[1]}), 64'd0);
    #2 rst_n = 1'b1;
    cyc();
    check("abort_idle", 64'({in_ready[1], busy[1]}), 64'b10);
    run_op(1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, 0, "post_reset");

    for (int k = 0; k < NINST; k++) begin
      repeat (1500) begin
        run_op(k, rand_operand(width_of(k)), rand_operand(width_of(k)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), $urandom_range(0, 3), "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
